// File: rtl/irq_ctrl.sv
// Interrupt controller: sticky external pending bits, internal causes taken at instruction boundaries.
// Optional macro IRQ_EDGE_DETECT_EN: external pending bits set on rising edges instead of levels.
module irq_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] int_cause,
    input  logic [31:0] sr,
    input  logic        commit,
    input  logic        eret,
    output logic        jisr,
    output logic [31:0] mca,
    output logic        rpt,
    output logic [4:0]  il,
    output logic        in_isr,
    output logic [25:0] ext_ack
);

    typedef enum logic [1:0] {RUN, TAKE, ISR, RET} state_t;

    state_t      state, state_next;
    logic [25:0] pending;
    logic [25:0] set_now;
    logic [31:0] masked;
    logic [31:0] take_vec;
    logic        take;
    logic [4:0]  il_next;

`ifdef IRQ_EDGE_DETECT_EN
    logic [25:0] history;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) history <= '0;
        else          history <= int_cause[31:6];
    end

    assign set_now = int_cause[31:6] & ~history;
`else
    assign set_now = int_cause[31:6];
`endif

    // Causes arriving this cycle are visible immediately so a commit can take them without delay.
    assign masked = {(pending | set_now) & sr[31:6], int_cause[5:0]};

    always_comb begin
        state_next = state;
        take       = 1'b0;
        take_vec   = masked;
        case (state)
            RUN: begin
                if (int_cause[0] || (commit && (|masked))) take = 1'b1;
            end
            TAKE: begin
                state_next = ISR;
            end
            ISR: begin
                take_vec = {26'b0, int_cause[5:0]};
                if (int_cause[0] || (commit && (|int_cause[5:0]))) take = 1'b1;
                else if (commit && eret)                           state_next = RET;
            end
            RET: begin
                take_vec = {26'b0, int_cause[5:0]};
                if (int_cause[0]) take = 1'b1;
                else              state_next = RUN;
            end
            default: state_next = RUN;
        endcase
        if (take) state_next = TAKE;
    end

    always_comb begin
        il_next = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (take_vec[i]) il_next = 5'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RUN;
            pending <= '0;
            mca     <= '0;
            il      <= '0;
            rpt     <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= (pending & ~ext_ack) | set_now;
            if (take) begin
                mca <= take_vec;
                il  <= il_next;
                rpt <= (il_next == 5'd3) || (il_next == 5'd4);
            end
        end
    end

    assign jisr    = (state == TAKE);
    assign in_isr  = (state == TAKE) || (state == ISR);
    assign ext_ack = (jisr && (il >= 5'd6)) ? (26'd1 << (il - 5'd6)) : 26'd0;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl; expectations are hand-computed per vector.
module tb_irq_ctrl;

    logic        clk;
    logic        reset_n;
    logic [31:0] int_cause;
    logic [31:0] sr;
    logic        commit;
    logic        eret;
    logic        jisr;
    logic [31:0] mca;
    logic        rpt;
    logic [4:0]  il;
    logic        in_isr;
    logic [25:0] ext_ack;

    int checks   = 0;
    int failures = 0;

    irq_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .int_cause (int_cause),
        .sr        (sr),
        .commit    (commit),
        .eret      (eret),
        .jisr      (jisr),
        .mca       (mca),
        .rpt       (rpt),
        .il        (il),
        .in_isr    (in_isr),
        .ext_ack   (ext_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then let one rising edge pass and settle.
    task automatic applyStimulus(input logic [31:0] cause, input logic [31:0] srv, input logic c, input logic e);
        int_cause = cause;
        sr        = srv;
        commit    = c;
        eret      = e;
        @(posedge clk);
        #1;
    endtask

    task automatic checkTake(input string tag, input logic [4:0] exp_il, input logic [31:0] exp_mca,
                             input logic exp_rpt, input logic [25:0] exp_ack);
        checkOutput({tag, "_jisr"}, 32'(jisr), 32'd1);
        checkOutput({tag, "_il"}, 32'(il), 32'(exp_il));
        checkOutput({tag, "_mca"}, mca, exp_mca);
        checkOutput({tag, "_rpt"}, 32'(rpt), 32'(exp_rpt));
        checkOutput({tag, "_ack"}, 32'(ext_ack), 32'(exp_ack));
        checkOutput({tag, "_inisr"}, 32'(in_isr), 32'd1);
    endtask

    task automatic returnToRun();
        applyStimulus(32'h0, 32'h0, 1'b1, 1'b1);
        checkOutput("ret_inisr", 32'(in_isr), 32'd0);
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n   = 1'b0;
        int_cause = 32'h0;
        sr        = 32'h0;
        commit    = 1'b0;
        eret      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_jisr", 32'(jisr), 32'd0);
        checkOutput("rst_inisr", 32'(in_isr), 32'd0);
        checkOutput("rst_mca", mca, 32'h0);
        checkOutput("rst_il", 32'(il), 32'd0);
        checkOutput("rst_ack", 32'(ext_ack), 32'd0);
        #3 reset_n = 1'b1;
        #1;

        // External cause 9 taken on commit, one-cycle latency
        applyStimulus(32'h0000_0200, 32'hFFFF_FFC0, 1'b1, 1'b0);
        checkTake("ext9", 5'd9, 32'h0000_0200, 1'b0, 26'h008);
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("isr_jisr", 32'(jisr), 32'd0);
        checkOutput("isr_inisr", 32'(in_isr), 32'd1);
        checkOutput("isr_ack", 32'(ext_ack), 32'd0);
        checkOutput("hold_il", 32'(il), 32'd9);
        returnToRun();
        checkOutput("run_inisr", 32'(in_isr), 32'd0);

        // Page faults 3 and 4: lowest wins, repeat instruction
        applyStimulus(32'h0000_0018, 32'h0, 1'b1, 1'b0);
        checkTake("pf", 5'd3, 32'h0000_0018, 1'b1, 26'h0);
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("pf_isr", 32'(in_isr), 32'd1);

        // Nested trap on same commit as eret: trap wins, no RET
        applyStimulus(32'h0000_0020, 32'h0, 1'b1, 1'b1);
        checkTake("nest", 5'd5, 32'h0000_0020, 1'b0, 26'h0);
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("nest_isr", 32'(in_isr), 32'd1);
        returnToRun();

        // Internal cause without commit is ignored
        applyStimulus(32'h0000_0002, 32'h0, 1'b0, 1'b0);
        checkOutput("nocommit_jisr", 32'(jisr), 32'd0);

        // Sticky pending: one-cycle pulse of cause 20 while masked
        applyStimulus(32'h0010_0000, 32'h0, 1'b0, 1'b0);
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("masked_jisr", 32'(jisr), 32'd0);
        applyStimulus(32'h0, 32'h0010_0000, 1'b1, 1'b0);
        checkTake("sticky20", 5'd20, 32'h0010_0000, 1'b0, 26'h0004000);
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
        returnToRun();

        // Priority internal over external; external 12 stays pending
        applyStimulus(32'h0000_1006, 32'hFFFF_FFC0, 1'b1, 1'b0);
        checkTake("prio", 5'd1, 32'h0000_1006, 1'b0, 26'h0);
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(32'h0, 32'hFFFF_FFC0, 1'b1, 1'b0);
        checkOutput("isr_nomask_jisr", 32'(jisr), 32'd0);
        checkOutput("isr_nomask_inisr", 32'(in_isr), 32'd1);
        returnToRun();
        applyStimulus(32'h0, 32'hFFFF_FFC0, 1'b1, 1'b0);
        checkTake("pend12", 5'd12, 32'h0000_1000, 1'b0, 26'h0000040);
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
        returnToRun();

        // Reset asserted mid-TAKE clears everything at once
        applyStimulus(32'h0000_0008, 32'h0, 1'b1, 1'b0);
        checkTake("pre_rst", 5'd3, 32'h0000_0008, 1'b1, 26'h0);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midrst_jisr", 32'(jisr), 32'd0);
        checkOutput("midrst_inisr", 32'(in_isr), 32'd0);
        checkOutput("midrst_mca", mca, 32'h0);
        checkOutput("midrst_il", 32'(il), 32'd0);
        checkOutput("midrst_rpt", 32'(rpt), 32'd0);
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
        #2 reset_n = 1'b1;
        #1;

        // Reset cause forces a take without commit
        applyStimulus(32'h0000_0001, 32'h0, 1'b0, 1'b0);
        checkTake("rstcause", 5'd0, 32'h0000_0001, 1'b0, 26'h0);
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
        returnToRun();

        // Cause 7 held high across two opportunities
        applyStimulus(32'h0000_0080, 32'hFFFF_FFC0, 1'b1, 1'b0);
        checkTake("hold7", 5'd7, 32'h0000_0080, 1'b0, 26'h0000002);
        applyStimulus(32'h0000_0080, 32'h0, 1'b0, 1'b0);
        applyStimulus(32'h0000_0080, 32'h0, 1'b1, 1'b1);
        applyStimulus(32'h0000_0080, 32'h0, 1'b0, 1'b0);
        applyStimulus(32'h0000_0080, 32'hFFFF_FFC0, 1'b1, 1'b0);
`ifdef IRQ_EDGE_DETECT_EN
        checkOutput("hold7_second_jisr", 32'(jisr), 32'd0);
`else
        checkOutput("hold7_second_jisr", 32'(jisr), 32'd1);
        checkOutput("hold7_second_il", 32'(il), 32'd7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port int_cause, input, 32: bit0 reset, bit1 illegal instr, bit2 misaligned, bit3 fetch page fault, bit4 load/store page fault, bit5 trap, bits 31:6 external devices.
REQ-004 SHALL have port sr, input, 32: current status register; sr[i]=1 enables maskable cause i (i>=6).
REQ-005 SHALL have port commit, input, 1: an instruction completes this cycle (instruction boundary).
REQ-006 SHALL have port eret, input, 1: committing instruction is eret.
REQ-007 SHALL have port jisr, output, 1: one-cycle pulse, jump to ISR; drives the SPR bank.
REQ-008 SHALL have port mca, output, 32: masked cause vector captured with jisr.
REQ-009 SHALL have port rpt, output, 1: 1 = repeat faulting instruction (epc = pc), 0 = continue (epc = next_pc).
REQ-010 SHALL have port il, output, 5: index of highest-priority cause taken.
REQ-011 SHALL have port in_isr, output, 1: handler active (between jisr and eret).
REQ-012 SHALL have port ext_ack, output, 26: one-cycle acknowledge of taken external cause (bit k-6 for cause k).

Function
REQ-013 SHALL hold external causes 31:6 in a sticky pending register; a bit sets on the input condition and clears only on its ext_ack or reset.
REQ-014 Internal causes 5:0 SHALL NOT be latched; they are sampled only in a commit cycle.
REQ-015 Masked vector SHALL be {pending[31:6] & sr[31:6], int_cause[5:0]}; bit0 additionally forces take regardless of commit.
REQ-016 Priority SHALL be lowest index highest; il = index of lowest set bit of masked vector.
REQ-017 FSM states SHALL be RUN, TAKE, ISR, RET.
REQ-018 RUN->TAKE when commit=1 and masked vector nonzero, or int_cause[0]=1 in any state.
REQ-019 TAKE SHALL last exactly one cycle with jisr=1, mca/il/rpt valid and stable; then ->ISR.
REQ-020 Latency: cause visible in commit cycle N -> jisr high in cycle N+1.
REQ-021 rpt SHALL be 1 iff il is 3 or 4; 0 otherwise (including reset cause).
REQ-022 ext_ack bit SHALL pulse in the TAKE cycle only for il>=6.
REQ-023 ISR: maskable causes keep pending but are not taken (SPR clears sr on jisr); internal causes with commit=1 ->TAKE (nested fault).
REQ-024 ISR->RET on commit=1 and eret=1; RET lasts one cycle, in_isr=0, no take in RET; then ->RUN.
REQ-025 Simultaneous eret and internal cause on same commit: internal cause wins, ->TAKE, eret ignored.
REQ-026 mca, il, rpt SHALL hold last captured value until next TAKE.
REQ-027 in_isr SHALL be 1 in TAKE and ISR, 0 in RUN and RET.

Reset
REQ-028 reset_n=0 SHALL immediately force RUN, pending=0, jisr=0, mca=0, il=0, rpt=0, in_isr=0, ext_ack=0, regardless of state, including mid-TAKE.
REQ-029 After reset_n release, the first edge SHALL evaluate causes normally.

Configuration
REQ-030 Macro IRQ_EDGE_DETECT_EN: defined -> pending bit sets on 0->1 transition of int_cause[k] (k>=6), one registered history stage; undefined -> pending bit sets while int_cause[k]=1 (level).

Verification
REQ-031 RUN, sr=0xFFFFFFC0, int_cause[9]=1, commit=1 at cycle 10 -> jisr=1 cycle 11, il=9, mca=0x00000200, rpt=0, ext_ack=0x008.
REQ-032 Commit with int_cause=0x00000018 -> il=3, rpt=1, mca=0x18; ISR entered, in_isr=1.
REQ-033 sr=0, int_cause[20] pulse one cycle, later sr[20]=1 with commit -> taken (sticky pending), il=20.
REQ-034 In ISR, commit+eret with int_cause[5]=1 -> TAKE, il=5, no RET state.
REQ-035 reset_n low during TAKE -> jisr=0 and all outputs 0 in same cycle; int_cause[0] alone later -> jisr next cycle without commit, il=0, rpt=0.
REQ-036 With IRQ_EDGE_DETECT_EN, int_cause[7] held high across two takes -> only one take; without macro -> pending re-sets, second take occurs.
